// File: rtl/uart_apb_master_if.sv
// Bus bundle for uart_apb_master: APB master signals plus the TX (s_*) and RX (m_*) byte streams.
// Streams use valid/ready: a byte moves on a rising edge where valid & ready are both 1; the sender holds valid and data stable until then.
interface uart_apb_master_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] paddr;
  logic                  pselx;
  logic                  penable;
  logic                  pwrite;
  logic [DATA_WIDTH-1:0] pwdata;
  logic                  pready;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pslverr;

  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;

  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;

  modport master (
    output paddr, pselx, penable, pwrite, pwdata,
    input  pready, prdata, pslverr,
    input  s_valid, s_data,
    output s_ready,
    output m_valid, m_data,
    input  m_ready
  );

  modport slave (
    input  paddr, pselx, penable, pwrite, pwdata,
    output pready, prdata, pslverr,
    output s_valid, s_data,
    input  s_ready,
    input  m_valid, m_data,
    output m_ready
  );
endinterface

// File: rtl/uart_apb_master.sv
// APB master bridging a TX byte stream to a UART TX register and RX register reads to an RX byte stream.
// Optional pready timeout enabled by defining UART_APB_MASTER_TIMEOUT_EN.
module uart_apb_master #(
  parameter int                    ADDR_WIDTH     = 4,
  parameter int                    DATA_WIDTH     = 8,
  parameter logic [ADDR_WIDTH-1:0] TX_ADDR        = 4'h0,
  parameter logic [ADDR_WIDTH-1:0] RX_ADDR        = 4'h1,
  parameter int                    TIMEOUT_CYCLES = 16
) (
  input  logic                pclk,
  input  logic                prst,
  input  logic                uart_irq,
  uart_apb_master_if.master   bus,
  output logic                err,
  output logic [1:0]          o_dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic                  r_pwrite;
  logic [DATA_WIDTH-1:0] r_pwdata;
  logic [DATA_WIDTH-1:0] r_m_data;
  logic                  r_m_valid;
  logic                  r_err;
  logic                  w_start_rd;
  logic                  w_start_wr;
  logic                  w_done;
  logic                  w_tmo;
  logic                  w_tmo_hit;
  logic                  w_s_ready;

`ifdef UART_APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_tmo_cnt;

  // Hit on the last allowed ACCESS cycle, so a stalled slave sees exactly TIMEOUT_CYCLES of them.
  assign w_tmo_hit = (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge pclk) begin
    if (prst) begin
      r_tmo_cnt <= '0;
    end else if (w_start_rd || w_start_wr) begin
      r_tmo_cnt <= '0;
    end else if (r_state == ACCESS) begin
      r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
    end
  end
`else
  logic w_unused_tmo;
  assign w_tmo_hit    = 1'b0;
  assign w_unused_tmo = (TIMEOUT_CYCLES == 0);
`endif

  always_comb begin
    w_next     = r_state;
    w_start_rd = 1'b0;
    w_start_wr = 1'b0;
    w_done     = 1'b0;
    w_tmo      = 1'b0;
    case (r_state)
      IDLE: begin
        // A pending RX byte wins, but only if the previous one has been taken.
        if (uart_irq && !r_m_valid) begin
          w_start_rd = 1'b1;
          w_next     = SETUP;
        end else if (bus.s_valid) begin
          w_start_wr = 1'b1;
          w_next     = SETUP;
        end
      end
      SETUP: w_next = ACCESS;
      ACCESS: begin
        if (bus.pready) begin
          w_done = 1'b1;
          w_next = IDLE;
        end else if (w_tmo_hit) begin
          w_tmo  = 1'b1;
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_s_ready = (r_state == IDLE) && !prst && !(uart_irq && !r_m_valid);

  always_ff @(posedge pclk) begin
    if (prst) begin
      r_state   <= IDLE;
      r_paddr   <= '0;
      r_pwrite  <= 1'b0;
      r_pwdata  <= '0;
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_next;
      r_err   <= (w_done && bus.pslverr) || w_tmo;
      if (w_start_rd) begin
        r_paddr  <= RX_ADDR;
        r_pwrite <= 1'b0;
      end else if (w_start_wr) begin
        r_paddr  <= TX_ADDR;
        r_pwrite <= 1'b1;
        r_pwdata <= bus.s_data;
      end
      if (r_m_valid && bus.m_ready) begin
        r_m_valid <= 1'b0;
      end else if (w_done && !r_pwrite && !bus.pslverr) begin
        r_m_valid <= 1'b1;
        r_m_data  <= bus.prdata;
      end
    end
  end

  assign bus.pselx   = (r_state != IDLE);
  assign bus.penable = (r_state == ACCESS);
  assign bus.paddr   = r_paddr;
  assign bus.pwrite  = r_pwrite;
  assign bus.pwdata  = r_pwdata;
  assign bus.s_ready = w_s_ready;
  assign bus.m_valid = r_m_valid;
  assign bus.m_data  = r_m_data;
  assign err         = r_err;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_uart_apb_master.sv
// Self-checking bench for uart_apb_master: scripted scenarios against a configurable APB slave model.
module tb_uart_apb_master;
  logic       pclk = 1'b0;
  logic       prst;
  logic       uart_irq;
  logic       err;
  logic [1:0] dbg_state;

  int errors = 0;
  int checks = 0;

  logic [7:0]  exp_q[$];
  logic [11:0] exp_wr_q[$];
  logic [11:0] wr_obs_q[$];

  int         slv_wait  = 0;
  logic [7:0] slv_rdata = 8'h00;
  logic       slv_err   = 1'b0;
  logic       slv_stall = 1'b0;
  int         acc_cnt;

  uart_apb_master_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) bus ();

  uart_apb_master dut (
    .pclk        (pclk),
    .prst        (prst),
    .uart_irq    (uart_irq),
    .bus         (bus),
    .err         (err),
    .o_dbg_state (dbg_state)
  );

  always #5 pclk = ~pclk;

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // APB slave: inserts slv_wait wait states (or stalls), returns slv_rdata/slv_err, logs good writes.
  initial begin
    bus.pready  = 1'b0;
    bus.prdata  = 8'h00;
    bus.pslverr = 1'b0;
    acc_cnt     = 0;
    forever begin
      @(posedge pclk);
      #1;
      if (bus.pselx && bus.penable) begin
        if (!slv_stall && acc_cnt >= slv_wait) begin
          bus.pready  = 1'b1;
          bus.prdata  = slv_rdata;
          bus.pslverr = slv_err;
          if (bus.pwrite && !slv_err) wr_obs_q.push_back({bus.paddr, bus.pwdata});
        end else begin
          bus.pready  = 1'b0;
          bus.pslverr = 1'b0;
        end
        acc_cnt++;
      end else begin
        bus.pready  = 1'b0;
        bus.pslverr = 1'b0;
        acc_cnt     = 0;
      end
    end
  end

  task automatic test_reset();
    prst = 1'b1; bus.s_valid = 1'b1; bus.s_data = 8'h11;
    tick(); tick();
    checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready: got %b want 0", bus.s_ready); end
    checks++; if ({bus.pselx, bus.penable, bus.pwrite} !== 3'b000) begin errors++; $display("FAIL reset_ctrl: got %b want 000", {bus.pselx, bus.penable, bus.pwrite}); end
    checks++; if ({bus.paddr, bus.pwdata} !== 12'h000) begin errors++; $display("FAIL reset_addr_data: got %h want 000", {bus.paddr, bus.pwdata}); end
    checks++; if ({bus.m_valid, bus.m_data, err} !== 10'h000) begin errors++; $display("FAIL reset_stream: got %h want 000", {bus.m_valid, bus.m_data, err}); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    bus.s_valid = 1'b0; prst = 1'b0;
    tick();
  endtask

  task automatic test_write();
    logic [11:0] obs;
    logic [11:0] exp;
    slv_wait = 0; slv_err = 1'b0;
    bus.s_valid = 1'b1; bus.s_data = 8'hA5;
    exp_wr_q.push_back({4'h0, 8'hA5});
    #1;
    checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL write_s_ready: got %b want 1", bus.s_ready); end
    tick();
    bus.s_valid = 1'b0; bus.s_data = 8'h00;
    #1;
    checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL write_s_ready_setup: got %b want 0", bus.s_ready); end
    checks++; if ({bus.pselx, bus.penable, bus.pwrite, bus.paddr, bus.pwdata} !== {3'b101, 4'h0, 8'hA5}) begin errors++; $display("FAIL write_setup: got %b_%h_%h want 101_0_a5", {bus.pselx, bus.penable, bus.pwrite}, bus.paddr, bus.pwdata); end
    tick();
    checks++; if ({bus.pselx, bus.penable, bus.pwrite, bus.paddr, bus.pwdata} !== {3'b111, 4'h0, 8'hA5}) begin errors++; $display("FAIL write_access: got %b_%h_%h want 111_0_a5", {bus.pselx, bus.penable, bus.pwrite}, bus.paddr, bus.pwdata); end
    tick();
    checks++; if ({bus.pselx, bus.penable, bus.pwrite, bus.pwdata} !== {3'b001, 8'hA5}) begin errors++; $display("FAIL write_end_hold: got %b_%h want 001_a5", {bus.pselx, bus.penable, bus.pwrite}, bus.pwdata); end
    obs = (wr_obs_q.size() > 0) ? wr_obs_q.pop_front() : 12'hxxx;
    exp = exp_wr_q.pop_front();
    checks++; if (obs !== exp) begin errors++; $display("FAIL write_slave_saw: got %h want %h", obs, exp); end
  endtask

  task automatic test_read();
    int n;
    logic stable;
    logic [7:0] exp;
    slv_wait = 2; slv_rdata = 8'h3C; slv_err = 1'b0;
    uart_irq = 1'b1; bus.m_ready = 1'b0;
    exp_q.push_back(8'h3C);
    tick();
    uart_irq = 1'b0;
    checks++; if ({bus.pselx, bus.penable, bus.pwrite, bus.paddr} !== {3'b100, 4'h1}) begin errors++; $display("FAIL read_setup: got %b_%h want 100_1", {bus.pselx, bus.penable, bus.pwrite}, bus.paddr); end
    n = 1;
    while (!bus.m_valid && n < 20) begin tick(); n++; end
    checks++; if (n !== 5) begin errors++; $display("FAIL read_latency: got %0d want 5 cycles", n); end
    exp = exp_q.pop_front();
    checks++; if ({bus.m_valid, bus.m_data} !== {1'b1, exp}) begin errors++; $display("FAIL read_data: got %b_%h want 1_%h", bus.m_valid, bus.m_data, exp); end
    stable = 1'b1;
    repeat (5) begin
      tick();
      if (bus.m_valid !== 1'b1 || bus.m_data !== exp) stable = 1'b0;
    end
    checks++; if (stable !== 1'b1) begin errors++; $display("FAIL read_hold: got %b want 1", stable); end
    bus.m_ready = 1'b1;
    tick();
    bus.m_ready = 1'b0;
    checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL read_clear: got %b want 0", bus.m_valid); end
  endtask

  task automatic test_priority_backpressure();
    int n;
    logic no_rd;
    logic [7:0] exp;
    logic [11:0] obs;
    logic [11:0] expw;
    slv_wait = 0; slv_rdata = 8'h77; slv_err = 1'b0;
    uart_irq = 1'b1; bus.s_valid = 1'b1; bus.s_data = 8'h5A;
    exp_q.push_back(8'h77);
    #1;
    checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL prio_s_ready: got %b want 0", bus.s_ready); end
    tick();
    checks++; if ({bus.pwrite, bus.paddr} !== {1'b0, 4'h1}) begin errors++; $display("FAIL prio_read_first: got %b_%h want 0_1", bus.pwrite, bus.paddr); end
    tick(); tick();
    exp = exp_q.pop_front();
    checks++; if ({bus.m_valid, bus.m_data} !== {1'b1, exp}) begin errors++; $display("FAIL prio_read_data: got %b_%h want 1_%h", bus.m_valid, bus.m_data, exp); end
    checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL bp_s_ready: got %b want 1", bus.s_ready); end
    exp_wr_q.push_back({4'h0, 8'h5A});
    tick();
    bus.s_valid = 1'b0;
    checks++; if ({bus.pselx, bus.pwrite, bus.paddr, bus.pwdata} !== {2'b11, 4'h0, 8'h5A}) begin errors++; $display("FAIL bp_write_setup: got %b_%h_%h want 11_0_5a", {bus.pselx, bus.pwrite}, bus.paddr, bus.pwdata); end
    tick(); tick();
    obs  = (wr_obs_q.size() > 0) ? wr_obs_q.pop_front() : 12'hxxx;
    expw = exp_wr_q.pop_front();
    checks++; if (obs !== expw) begin errors++; $display("FAIL bp_write_slave_saw: got %h want %h", obs, expw); end
    no_rd = 1'b1;
    repeat (6) begin
      tick();
      if (bus.pselx !== 1'b0 || bus.m_valid !== 1'b1) no_rd = 1'b0;
    end
    checks++; if (no_rd !== 1'b1) begin errors++; $display("FAIL bp_no_second_read: got %b want 1", no_rd); end
    bus.m_ready = 1'b1; slv_rdata = 8'h42;
    exp_q.push_back(8'h42);
    tick();
    bus.m_ready = 1'b0;
    checks++; if ({bus.m_valid, bus.pselx} !== 2'b00) begin errors++; $display("FAIL bp_release: got %b want 00", {bus.m_valid, bus.pselx}); end
    tick();
    uart_irq = 1'b0;
    checks++; if ({bus.pselx, bus.penable, bus.pwrite, bus.paddr} !== {3'b100, 4'h1}) begin errors++; $display("FAIL bp_read_restart: got %b_%h want 100_1", {bus.pselx, bus.penable, bus.pwrite}, bus.paddr); end
    n = 0;
    while (!bus.m_valid && n < 20) begin tick(); n++; end
    exp = exp_q.pop_front();
    checks++; if ({bus.m_valid, bus.m_data} !== {1'b1, exp}) begin errors++; $display("FAIL bp_second_read: got %b_%h want 1_%h", bus.m_valid, bus.m_data, exp); end
    bus.m_ready = 1'b1;
    tick();
    bus.m_ready = 1'b0;
  endtask

  task automatic test_error();
    int err_cnt;
    logic mv;
    logic [11:0] obs;
    logic [11:0] expw;
    slv_wait = 0; slv_err = 1'b1;
    bus.s_valid = 1'b1; bus.s_data = 8'hA1;
    tick();
    bus.s_valid = 1'b0;
    tick(); tick();
    checks++; if ({err, bus.pselx} !== 2'b10) begin errors++; $display("FAIL err_write_pulse: got %b want 10", {err, bus.pselx}); end
    tick();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_write_single: got %b want 0", err); end
    checks++; if (wr_obs_q.size() !== 0) begin errors++; $display("FAIL err_write_dropped: got %0d want 0 writes", wr_obs_q.size()); end
    slv_err = 1'b0;
    bus.s_valid = 1'b1; bus.s_data = 8'hB2;
    exp_wr_q.push_back({4'h0, 8'hB2});
    #1;
    checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL err_next_accept: got %b want 1", bus.s_ready); end
    tick();
    bus.s_valid = 1'b0;
    tick(); tick();
    obs  = (wr_obs_q.size() > 0) ? wr_obs_q.pop_front() : 12'hxxx;
    expw = exp_wr_q.pop_front();
    checks++; if ({err, obs} !== {1'b0, expw}) begin errors++; $display("FAIL err_next_write: got %b_%h want 0_%h", err, obs, expw); end
    slv_err = 1'b1; uart_irq = 1'b1;
    err_cnt = 0; mv = 1'b0;
    tick();
    uart_irq = 1'b0;
    repeat (5) begin
      tick();
      if (err === 1'b1) err_cnt++;
      if (bus.m_valid !== 1'b0) mv = 1'b1;
    end
    checks++; if (err_cnt !== 1) begin errors++; $display("FAIL err_read_pulse: got %0d want 1 cycles", err_cnt); end
    checks++; if (mv !== 1'b0) begin errors++; $display("FAIL err_read_no_mvalid: got %b want 0", mv); end
    slv_err = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp;
    slv_wait = 0; slv_rdata = 8'hC3; uart_irq = 1'b1;
    exp_q.push_back(8'hC3);
    tick();
    uart_irq = 1'b0;
    tick(); tick();
    exp = exp_q.pop_front();
    checks++; if ({bus.m_valid, bus.m_data} !== {1'b1, exp}) begin errors++; $display("FAIL rst_mid_held: got %b_%h want 1_%h", bus.m_valid, bus.m_data, exp); end
    slv_stall = 1'b1;
    bus.s_valid = 1'b1; bus.s_data = 8'h99;
    tick();
    bus.s_valid = 1'b0;
    tick();
    checks++; if (bus.penable !== 1'b1) begin errors++; $display("FAIL rst_mid_in_access: got %b want 1", bus.penable); end
    prst = 1'b1;
    tick();
    prst = 1'b0;
    checks++; if ({bus.pselx, bus.penable, bus.m_valid, err} !== 4'b0000) begin errors++; $display("FAIL rst_mid_abort: got %b want 0000", {bus.pselx, bus.penable, bus.m_valid, err}); end
    checks++; if ({bus.m_data, dbg_state} !== 10'h000) begin errors++; $display("FAIL rst_mid_state: got %h want 000", {bus.m_data, dbg_state}); end
    slv_stall = 1'b0;
    tick();
    checks++; if ({bus.pselx, err} !== 2'b00) begin errors++; $display("FAIL rst_mid_after: got %b want 00", {bus.pselx, err}); end
    checks++; if (wr_obs_q.size() !== 0) begin errors++; $display("FAIL rst_mid_no_write: got %0d want 0 writes", wr_obs_q.size()); end
  endtask

  task automatic test_timeout();
    int n;
    int acc;
    int err_seen;
    slv_wait = 0; slv_stall = 1'b1;
    bus.s_valid = 1'b1; bus.s_data = 8'h3E;
`ifndef UART_APB_MASTER_TIMEOUT_EN
    exp_wr_q.push_back({4'h0, 8'h3E});
`endif
    tick();
    bus.s_valid = 1'b0;
    n = 0; acc = 0; err_seen = 0;
    while (n < 150) begin
      tick();
      n++;
      if (bus.penable === 1'b1) acc++;
      if (err === 1'b1) err_seen++;
      if (bus.pselx !== 1'b1) break;
`ifndef UART_APB_MASTER_TIMEOUT_EN
      if (n >= 110) break;
`endif
    end
`ifdef UART_APB_MASTER_TIMEOUT_EN
    checks++; if (acc !== 16) begin errors++; $display("FAIL tmo_access_cycles: got %0d want 16", acc); end
    checks++; if ({err_seen[1:0], dbg_state} !== 4'b0100) begin errors++; $display("FAIL tmo_err_idle: got err=%0d state=%0d want 1/0", err_seen, dbg_state); end
    slv_stall = 1'b0;
    tick();
    checks++; if ({err, wr_obs_q.size() == 0} !== 2'b01) begin errors++; $display("FAIL tmo_after: got %b want 01", {err, wr_obs_q.size() == 0}); end
`else
    begin
      logic [11:0] obs;
      logic [11:0] expw;
      checks++; if (acc !== 110) begin errors++; $display("FAIL notmo_access_cycles: got %0d want 110", acc); end
      checks++; if (err_seen !== 0) begin errors++; $display("FAIL notmo_no_err: got %0d want 0", err_seen); end
      slv_stall = 1'b0;
      n = 0;
      while (bus.pselx && n < 5) begin tick(); n++; end
      checks++; if (bus.pselx !== 1'b0) begin errors++; $display("FAIL notmo_release: got %b want 0", bus.pselx); end
      obs  = (wr_obs_q.size() > 0) ? wr_obs_q.pop_front() : 12'hxxx;
      expw = exp_wr_q.pop_front();
      checks++; if (obs !== expw) begin errors++; $display("FAIL notmo_write_saw: got %h want %h", obs, expw); end
    end
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    prst = 1'b1; uart_irq = 1'b0;
    bus.s_valid = 1'b0; bus.s_data = 8'h00; bus.m_ready = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_priority_backpressure();
    test_error();
    test_reset_mid();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
